// File: rtl/msp_pkg.sv
// Shared constants, FSM state type and saturation helper for the msp_frame_slicer
// framing stage (also referenced when instantiating MEL_SPEC).
package msp_pkg;
  localparam int MSP_WIDTH    = 16;
  localparam int MSP_WIN_LEN  = 480;
  localparam int MSP_HOP_LEN  = 160;
  localparam int MSP_N_FFT    = 512;
  localparam int MSP_N_FRAMES = 101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    EMIT   = 3'd2,
    PAD    = 3'd3,
    RETIRE = 3'd4,
    DONE   = 3'd5
  } slicer_state_t;

  // Clamp a WIDTH+2 two's-complement value into signed WIDTH.
  function automatic logic [MSP_WIDTH-1:0] msp_sat(input logic [MSP_WIDTH+1:0] v);
    logic [MSP_WIDTH-1:0] r;
    if (v[MSP_WIDTH+1:MSP_WIDTH-1] == {3{v[MSP_WIDTH+1]}}) begin
      r = v[MSP_WIDTH-1:0];
    end else if (v[MSP_WIDTH+1]) begin
      r = {1'b1, {(MSP_WIDTH-1){1'b0}}};
    end else begin
      r = {1'b0, {(MSP_WIDTH-1){1'b1}}};
    end
    return r;
  endfunction
endpackage

// File: rtl/msp_slicer_ram.sv
// Sample store for msp_frame_slicer: DEPTH x WIDTH, one write port and one
// registered read port, written so that it maps onto block RAM.
module msp_slicer_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Write port plus registered read; no reset so it stays a RAM primitive.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/msp_frame_slicer.sv
// Circular-buffer framer feeding MEL_SPEC: WIN_LEN samples + zero pad per frame,
// HOP_LEN advance. Define MSP_SLICER_PREEMPH_EN to pre-emphasise samples on write.
module msp_frame_slicer
  import msp_pkg::*;
#(
  parameter int WIDTH    = MSP_WIDTH,
  parameter int WIN_LEN  = MSP_WIN_LEN,
  parameter int HOP_LEN  = MSP_HOP_LEN,
  parameter int N_FFT    = MSP_N_FFT,
  parameter int N_FRAMES = MSP_N_FRAMES
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              seq_start,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH-1:0]                  in_data,
  output logic                              frm_start,
  output logic                              out_valid,
  output logic [WIDTH-1:0]                  out_re,
  output logic [WIDTH-1:0]                  out_im,
  output logic                              out_last,
  output logic [$clog2(N_FRAMES+1)-1:0]     frm_idx,
  output logic                              seq_done
);
  localparam int DEPTH = WIN_LEN + HOP_LEN;
  localparam int AW    = $clog2(DEPTH);
  localparam int FW    = $clog2(DEPTH + 1);
  localparam int KW    = $clog2(N_FFT);
  localparam int IW    = $clog2(N_FRAMES + 1);

  localparam logic [FW-1:0] DEPTH_F    = FW'(DEPTH);
  localparam logic [FW-1:0] WIN_F      = FW'(WIN_LEN);
  localparam logic [FW-1:0] HOP_F      = FW'(HOP_LEN);
  localparam logic [AW-1:0] PTR_LAST   = AW'(DEPTH - 1);
  localparam logic [AW:0]   HOP_B      = (AW+1)'(HOP_LEN);
  localparam logic [AW:0]   DEPTH_B    = (AW+1)'(DEPTH);
  localparam logic [KW-1:0] K_WIN_LAST = KW'(WIN_LEN - 1);
  localparam logic [KW-1:0] K_FFT_LAST = KW'(N_FFT - 1);
  localparam logic [IW-1:0] FRM_LAST   = IW'(N_FRAMES - 1);

  slicer_state_t    state_r, state_s;
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r, base_r;
  logic [AW-1:0]    wr_ptr_inc_s, rd_ptr_inc_s, base_next_s;
  logic [AW:0]      base_sum_s;
  logic [FW-1:0]    fill_r, fill_s;
  logic [KW-1:0]    k_r;
  logic [IW-1:0]    frm_cnt_r;
  logic             in_ready_r, ready_s, wr_s, emitting_s;
  logic             s1_valid_r, s1_pad_r, s1_first_r, s1_last_r;
  logic [WIDTH-1:0] wdata_s, rd_data_s;

  assign in_ready   = in_ready_r;
  assign frm_idx    = frm_cnt_r;
  assign out_im     = {WIDTH{1'b0}};
  assign wr_s       = in_valid && in_ready_r && !seq_start;
  assign emitting_s = (state_r == EMIT) || (state_r == PAD);

`ifdef MSP_SLICER_PREEMPH_EN
  logic [WIDTH-1:0] x_prev_r;
  logic [WIDTH+1:0] pe_sum_s;

  assign pe_sum_s = {{2{in_data[WIDTH-1]}}, in_data} - {{2{x_prev_r[WIDTH-1]}}, x_prev_r}
                  + {{7{x_prev_r[WIDTH-1]}}, x_prev_r[WIDTH-1:5]};
  assign wdata_s  = msp_sat(pe_sum_s);

  // Previous accepted sample; x[-1] is zero at the start of every utterance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_prev_r <= {WIDTH{1'b0}};
    end else if (seq_start) begin
      x_prev_r <= {WIDTH{1'b0}};
    end else if (wr_s) begin
      x_prev_r <= in_data;
    end else begin
      x_prev_r <= x_prev_r;
    end
  end
`else
  assign wdata_s = in_data;
`endif

  // Pointer wraps are compare-and-clear because DEPTH is not a power of two.
  always_comb begin
    wr_ptr_inc_s = (wr_ptr_r == PTR_LAST) ? {AW{1'b0}} : wr_ptr_r + 1'b1;
    rd_ptr_inc_s = (rd_ptr_r == PTR_LAST) ? {AW{1'b0}} : rd_ptr_r + 1'b1;
    base_sum_s   = {1'b0, base_r} + HOP_B;
    base_next_s  = (base_sum_s >= DEPTH_B) ? AW'(base_sum_s - DEPTH_B) : base_sum_s[AW-1:0];
  end

  // Next state, fill and the next-cycle in_ready; seq_start overrides everything.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (seq_start) state_s = WAIT; else state_s = IDLE;
      WAIT:    if (fill_r >= WIN_F) state_s = EMIT; else state_s = WAIT;
      EMIT:    if (k_r == K_WIN_LAST) state_s = (N_FFT > WIN_LEN) ? PAD : RETIRE;
               else state_s = EMIT;
      PAD:     if (k_r == K_FFT_LAST) state_s = RETIRE; else state_s = PAD;
      RETIRE:  if (frm_cnt_r == FRM_LAST) state_s = DONE; else state_s = WAIT;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase

    fill_s = fill_r;
    if (seq_start) begin
      state_s = WAIT;
      fill_s  = {FW{1'b0}};
    end else begin
      if (wr_s) fill_s = fill_s + 1'b1; else fill_s = fill_s;
      if (state_r == RETIRE) fill_s = fill_s - HOP_F; else fill_s = fill_s;
    end

    ready_s = (state_s inside {WAIT, EMIT, PAD, RETIRE}) && (fill_s < DEPTH_F);
  end

  // Control state, buffer pointers and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      fill_r     <= {FW{1'b0}};
      in_ready_r <= 1'b0;
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      base_r     <= {AW{1'b0}};
      k_r        <= {KW{1'b0}};
      frm_cnt_r  <= {IW{1'b0}};
    end else begin
      state_r    <= state_s;
      fill_r     <= fill_s;
      in_ready_r <= ready_s;
      if (seq_start) begin
        wr_ptr_r  <= {AW{1'b0}};
        rd_ptr_r  <= {AW{1'b0}};
        base_r    <= {AW{1'b0}};
        k_r       <= {KW{1'b0}};
        frm_cnt_r <= {IW{1'b0}};
      end else begin
        if (wr_s) wr_ptr_r <= wr_ptr_inc_s;
        if (state_r == WAIT) rd_ptr_r <= base_r;
        else if (state_r == EMIT) rd_ptr_r <= rd_ptr_inc_s;
        if (emitting_s) k_r <= k_r + 1'b1;
        else k_r <= {KW{1'b0}};
        if (state_r == RETIRE) begin
          base_r    <= base_next_s;
          frm_cnt_r <= frm_cnt_r + 1'b1;
        end
      end
    end
  end

  msp_slicer_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_s),
    .waddr (wr_ptr_r),
    .wdata (wdata_s),
    .raddr (rd_ptr_r),
    .rdata (rd_data_s)
  );

  // Stage 1 tags line up with the RAM read; stage 2 drives the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_pad_r   <= 1'b0;
      s1_first_r <= 1'b0;
      s1_last_r  <= 1'b0;
      out_valid  <= 1'b0;
      frm_start  <= 1'b0;
      out_last   <= 1'b0;
      out_re     <= {WIDTH{1'b0}};
      seq_done   <= 1'b0;
    end else if (seq_start) begin
      s1_valid_r <= 1'b0;
      s1_pad_r   <= 1'b0;
      s1_first_r <= 1'b0;
      s1_last_r  <= 1'b0;
      out_valid  <= 1'b0;
      frm_start  <= 1'b0;
      out_last   <= 1'b0;
      out_re     <= {WIDTH{1'b0}};
      seq_done   <= 1'b0;
    end else begin
      s1_valid_r <= emitting_s;
      s1_pad_r   <= (state_r == PAD);
      s1_first_r <= (state_r == EMIT) && (k_r == {KW{1'b0}});
      s1_last_r  <= emitting_s && (k_r == K_FFT_LAST);
      out_valid  <= s1_valid_r;
      frm_start  <= s1_valid_r && s1_first_r;
      out_last   <= s1_valid_r && s1_last_r;
      out_re     <= (s1_valid_r && !s1_pad_r) ? rd_data_s : {WIDTH{1'b0}};
      seq_done   <= (state_s == DONE);
    end
  end
endmodule
